// File: rtl/mini_core_fetch_if.sv
// rtl/mini_core_fetch_if.sv - instruction memory request/response bus
// Purpose: groups the fetch-to-instruction-memory handshake.
// Ports:
//   IMemReq/IMemAddr   request from fetch (address word aligned)
//   IMemGnt            memory accepts the request this cycle
//   IMemRspValid/Data  in-order read response
// Modports: master = fetch stage, slave = instruction memory.
interface mini_core_fetch_if;
    logic        IMemReq;
    logic [31:0] IMemAddr;
    logic        IMemGnt;
    logic        IMemRspValid;
    logic [31:0] IMemRspData;

    modport master (
        output IMemReq,
        output IMemAddr,
        input  IMemGnt,
        input  IMemRspValid,
        input  IMemRspData
    );

    modport slave (
        input  IMemReq,
        input  IMemAddr,
        output IMemGnt,
        output IMemRspValid,
        output IMemRspData
    );
endinterface

// File: rtl/mini_core_fetch.sv
// rtl/mini_core_fetch.sv - Q100H instruction fetch stage with fetch queue
// Purpose: owns the PC, issues in-order instruction reads, buffers returned
// words in a small fetch queue and presents them to decode at Q101H.
// Ports:
//   Clock, Rst                 clock, asynchronous active-high reset
//   ReadyQ100H                 fetch may advance (low on freeze / load hazard)
//   ReadyQ101H                 decode consumes the Q101H instruction
//   SelNextPcAluOutQ102H       redirect request, target on AluOutQ102H
//   iMem                       instruction memory bus (master side)
//   PreInstructionQ101H        instruction to decode (NOP when empty)
//   PcQ101H                    PC of that instruction (0 when empty)
//   InstValidQ101H             Q101H holds a real fetched instruction
module mini_core_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          FQ_DEPTH = 2
) (
    input  logic               Clock,
    input  logic               Rst,
    input  logic               ReadyQ100H,
    input  logic               ReadyQ101H,
    input  logic               SelNextPcAluOutQ102H,
    input  logic [31:0]        AluOutQ102H,
    mini_core_fetch_if.master  iMem,
    output logic [31:0]        PreInstructionQ101H,
    output logic [31:0]        PcQ101H,
    output logic               InstValidQ101H
);

    localparam int          CNT_W = $clog2(FQ_DEPTH + 1);
    localparam int          PTR_W = $clog2(FQ_DEPTH);
    localparam logic [31:0] NOP   = 32'h0000_0013;

    // Pointer increment that also works for non power-of-two depths.
    function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FQ_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    logic [31:0]      pcQ100H;
    logic [CNT_W-1:0] outCnt;
    logic [CNT_W-1:0] dropCnt;
    logic [CNT_W-1:0] fqCount;
    logic [PTR_W-1:0] fqRdPtr;
    logic [PTR_W-1:0] fqWrPtr;
    logic [PTR_W-1:0] pfRdPtr;
    logic [PTR_W-1:0] pfWrPtr;

    logic [31:0] fqInstr [FQ_DEPTH];
    logic [31:0] fqPc    [FQ_DEPTH];
    // PCs of outstanding requests, in issue order; responses pop it.
    logic [31:0] pcFifo  [FQ_DEPTH];

    logic             redir;
    logic             pop;
    logic             rspOk;
    logic             drop;
    logic             push;
    logic             grant;
    logic             fqFull;
    logic [CNT_W:0]   creditsUsed;
    logic [31:0]      fetchAddr;

    always_comb begin
        // A redirect held across a freeze must not fire until the core moves.
        redir       = SelNextPcAluOutQ102H && ReadyQ100H;
        pop         = ReadyQ101H && (fqCount != '0) && !redir;
        // A response with nothing outstanding is ignored.
        rspOk       = iMem.IMemRspValid && (outCnt != '0);
        drop        = rspOk && (dropCnt != '0);
        push        = rspOk && (dropCnt == '0) && !redir;
        fqFull      = (fqCount == CNT_W'(FQ_DEPTH));
        fetchAddr   = {pcQ100H[31:2], 2'b00};
        // Outstanding requests plus queued words must leave room for the
        // new response, so a request is only made with a free queue slot.
        creditsUsed = {1'b0, outCnt} + {1'b0, fqCount} - {{CNT_W{1'b0}}, pop};
        iMem.IMemReq  = !Rst && ReadyQ100H && !redir
                        && (creditsUsed < (CNT_W + 1)'(FQ_DEPTH));
        iMem.IMemAddr = fetchAddr;
        grant       = iMem.IMemReq && iMem.IMemGnt;
    end

    always_ff @(posedge Clock or posedge Rst) begin
        if (Rst) begin
            pcQ100H <= RESET_PC;
            outCnt  <= '0;
            dropCnt <= '0;
            fqCount <= '0;
            fqRdPtr <= '0;
            fqWrPtr <= '0;
            pfRdPtr <= '0;
            pfWrPtr <= '0;
        end else begin
            outCnt <= outCnt + CNT_W'(grant) - CNT_W'(rspOk);
            if (grant) begin
                pfWrPtr <= nextPtr(pfWrPtr);
            end
            // The PC FIFO tracks every outstanding request, dropped or not.
            if (rspOk) begin
                pfRdPtr <= nextPtr(pfRdPtr);
            end
            if (redir) begin
                pcQ100H <= AluOutQ102H;
                fqCount <= '0;
                fqRdPtr <= '0;
                fqWrPtr <= '0;
                // Everything still in flight after this cycle is stale.
                dropCnt <= outCnt - CNT_W'(rspOk);
            end else begin
                if (grant) begin
                    pcQ100H <= pcQ100H + 32'd4;
                end
                fqCount <= fqCount + CNT_W'(push) - CNT_W'(pop);
                if (push) begin
                    fqWrPtr <= nextPtr(fqWrPtr);
                end
                if (pop) begin
                    fqRdPtr <= nextPtr(fqRdPtr);
                end
                if (drop) begin
                    dropCnt <= dropCnt - CNT_W'(1);
                end
            end
        end
    end

    // Storage arrays carry no reset; validity is tracked by the counters.
    always_ff @(posedge Clock) begin
        if (grant) begin
            pcFifo[pfWrPtr] <= fetchAddr;
        end
        if (push) begin
            fqInstr[fqWrPtr] <= iMem.IMemRspData;
            fqPc[fqWrPtr]    <= pcFifo[pfRdPtr];
        end
    end

    always_comb begin
        InstValidQ101H      = 1'b0;
        PreInstructionQ101H = NOP;
        PcQ101H             = 32'h0000_0000;
        if (fqCount != '0) begin
            InstValidQ101H      = 1'b1;
            PreInstructionQ101H = fqInstr[fqRdPtr];
            PcQ101H             = fqPc[fqRdPtr];
        end
    end

    assertNoPushWhenFull: assert property (
        @(posedge Clock) disable iff (Rst) !(push && fqFull));

    assertNoOrphanResponse: assert property (
        @(posedge Clock) disable iff (Rst) !(iMem.IMemRspValid && outCnt == '0));

endmodule

// File: tb/tb_mini_core_fetch.sv
// tb/tb_mini_core_fetch.sv - randomized self-checking bench for mini_core_fetch
module tb_mini_core_fetch;

    localparam int          FQ_DEPTH = 2;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic        readyQ100H;
    logic        readyQ101H;
    logic        selNextPc;
    logic [31:0] aluOut;
    logic [31:0] preInstr;
    logic [31:0] pcQ101H;
    logic        instValid;

    mini_core_fetch_if imemIf ();

    mini_core_fetch #(
        .RESET_PC (RESET_PC),
        .FQ_DEPTH (FQ_DEPTH)
    ) dut (
        .Clock                (clk),
        .Rst                  (rst),
        .ReadyQ100H           (readyQ100H),
        .ReadyQ101H           (readyQ101H),
        .SelNextPcAluOutQ102H (selNextPc),
        .AluOutQ102H          (aluOut),
        .iMem                 (imemIf),
        .PreInstructionQ101H  (preInstr),
        .PcQ101H              (pcQ101H),
        .InstValidQ101H       (instValid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int numVectors;
    int numMiscompares;

    // Reference model: fetch PC, outstanding requests with a stale flag,
    // and the fetch queue as plain queues.
    logic [31:0] mPc;
    logic [31:0] outPc[$];
    bit          outStale[$];
    logic [31:0] fqPcQ[$];
    logic [31:0] fqInsQ[$];
    // Memory environment: addresses granted and not yet answered.
    logic [31:0] memQ[$];

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        numVectors++;
        if (obs !== exp) begin
            numMiscompares++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] memWord(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic modelReset();
        mPc = RESET_PC;
        outPc.delete();
        outStale.delete();
        fqPcQ.delete();
        fqInsQ.delete();
        memQ.delete();
    endtask

    task automatic checkResetOutputs(input string tag);
        checkVal({tag, "_req"},   32'(imemIf.IMemReq), 32'd0);
        checkVal({tag, "_valid"}, 32'(instValid), 32'd0);
        checkVal({tag, "_instr"}, preInstr, NOP);
        checkVal({tag, "_pc"},    pcQ101H, 32'd0);
    endtask

    // Entered just after a rising edge; returns just after the next one.
    task automatic runCycle(input int pR100, input int pR101, input int pSel,
                            input int pGnt, input int pRsp);
        bit          redir;
        bit          pop;
        bit          req;
        bit          grant;
        bit          st;
        int          used;
        logic [31:0] rPc;

        readyQ100H = ($urandom_range(99) < pR100);
        readyQ101H = ($urandom_range(99) < pR101);
        selNextPc  = ($urandom_range(99) < pSel);
        aluOut     = ($urandom_range(3) == 0) ? $urandom : ($urandom & 32'h0000_0FFC);
        imemIf.IMemGnt = ($urandom_range(99) < pGnt);
        if (memQ.size() != 0 && $urandom_range(99) < pRsp) begin
            imemIf.IMemRspValid = 1'b1;
            imemIf.IMemRspData  = memWord(memQ[0]);
        end else begin
            imemIf.IMemRspValid = 1'b0;
            imemIf.IMemRspData  = $urandom;
        end

        @(negedge clk);
        redir = selNextPc && readyQ100H;
        pop   = readyQ101H && fqPcQ.size() != 0 && !redir;
        used  = outPc.size() + fqPcQ.size() - int'(pop);
        req   = readyQ100H && !redir && used < FQ_DEPTH;

        checkVal("req", 32'(imemIf.IMemReq), 32'(req));
        if (req) checkVal("addr", imemIf.IMemAddr, {mPc[31:2], 2'b00});
        if (fqPcQ.size() != 0) begin
            checkVal("valid", 32'(instValid), 32'd1);
            checkVal("pc",    pcQ101H, fqPcQ[0]);
            checkVal("instr", preInstr, fqInsQ[0]);
        end else begin
            checkVal("valid_empty", 32'(instValid), 32'd0);
            checkVal("pc_empty",    pcQ101H, 32'd0);
            checkVal("instr_empty", preInstr, NOP);
        end

        // Environment update from what actually crossed the bus.
        if (imemIf.IMemRspValid) void'(memQ.pop_front());
        if (imemIf.IMemReq && imemIf.IMemGnt) memQ.push_back(imemIf.IMemAddr);

        // Model update for the coming edge.
        grant = req && imemIf.IMemGnt;
        if (pop) begin
            void'(fqPcQ.pop_front());
            void'(fqInsQ.pop_front());
        end
        if (imemIf.IMemRspValid && outPc.size() != 0) begin
            rPc = outPc.pop_front();
            st  = outStale.pop_front();
            if (!st && !redir) begin
                fqPcQ.push_back(rPc);
                fqInsQ.push_back(memWord(rPc));
            end
        end
        if (redir) begin
            foreach (outStale[i]) outStale[i] = 1'b1;
            fqPcQ.delete();
            fqInsQ.delete();
            mPc = aluOut;
        end
        if (grant) begin
            outPc.push_back({mPc[31:2], 2'b00});
            outStale.push_back(1'b0);
            mPc = mPc + 32'd4;
        end

        @(posedge clk);
        #1;
    endtask

    task automatic idleInputs();
        readyQ100H          = 1'b0;
        readyQ101H          = 1'b0;
        selNextPc           = 1'b0;
        aluOut              = 32'd0;
        imemIf.IMemGnt      = 1'b0;
        imemIf.IMemRspValid = 1'b0;
        imemIf.IMemRspData  = 32'd0;
    endtask

    // Asserts reset off the clock edge, checks outputs at once, releases
    // off the edge too; the memory side is cleared concurrently.
    task automatic asyncResetPulse();
        #2;
        rst = 1'b1;
        idleInputs();
        #1;
        checkResetOutputs("midrst");
        modelReset();
        @(posedge clk);
        #3;
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        numVectors     = 0;
        numMiscompares = 0;
        rst            = 1'b1;
        idleInputs();
        modelReset();
        #2;
        checkResetOutputs("reset");
        readyQ100H = 1'b1;
        #1;
        checkVal("reset_req_ready", 32'(imemIf.IMemReq), 32'd0);
        readyQ100H = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #3;
        rst = 1'b0;
        @(posedge clk);
        #1;

        repeat (12)   runCycle(100, 100,  0, 100, 100);
        repeat (40)   runCycle(100,  40,  0, 100, 100);
        repeat (60)   runCycle(100,  90, 15, 100, 100);
        repeat (60)   runCycle(100,  80,  0,  50,  60);
        repeat (60)   runCycle( 50,  80, 40,  80,  80);
        asyncResetPulse();
        repeat (12)   runCycle(100, 100,  0, 100, 100);
        repeat (3000) runCycle( 85,  75,  8,  70,  70);
        asyncResetPulse();
        repeat (30)   runCycle( 90,  70, 10,  60,  60);

        $display("== %0d vectors applied, %0d miscompares ==", numVectors, numMiscompares);
        $finish;
    end

endmodule
